// File: rtl/player_input_arbiter_pkg.sv
// Shared types and constants for the player input arbiter slice:
// FSM state encoding, the 4-bit command struct and the jitter LFSR step.
package player_ctrl_pkg;

   localparam logic [1:0] ST_LOCK  = 2'd0;
   localparam logic [1:0] ST_AI    = 2'd1;
   localparam logic [1:0] ST_HUMAN = 2'd2;

   typedef enum logic [1:0] {
      LOCK  = ST_LOCK,
      AI    = ST_AI,
      HUMAN = ST_HUMAN
   } arb_state_t;

   typedef struct packed {
      logic left;
      logic right;
      logic jump;
      logic smash;
   } ply_cmd_t;

   localparam logic [7:0] LFSR_SEED = 8'hA5;

   // Fibonacci form of x^8+x^6+x^5+x^4+1, shifting towards the MSB
   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

endpackage

// File: rtl/player_input_arbiter_if.sv
// Command/result bundle between key decode, the computer player and physics.
// master drives commands and frame timing; slave is the arbiter.
interface player_input_arbiter_if;

   logic       frame_tick;
   logic       game_active;
   logic       hum_left, hum_right, hum_jump, hum_smash;
   logic       ai_left, ai_right, ai_jump, ai_smash;
   logic       out_move_left, out_move_right, out_jump, out_smash;
   logic       src_is_ai;
   logic [1:0] arb_state;

   modport master (
      output frame_tick, game_active,
      output hum_left, hum_right, hum_jump, hum_smash,
      output ai_left, ai_right, ai_jump, ai_smash,
      input  out_move_left, out_move_right, out_jump, out_smash,
      input  src_is_ai, arb_state
   );

   modport slave (
      input  frame_tick, game_active,
      input  hum_left, hum_right, hum_jump, hum_smash,
      input  ai_left, ai_right, ai_jump, ai_smash,
      output out_move_left, out_move_right, out_jump, out_smash,
      output src_is_ai, arb_state
   );

endinterface

// File: rtl/player_input_arbiter_react_delay_line.sv
// Frame-stepped shift register of AI commands modelling reaction time.
// DEPTH=0 makes the line a plain wire from din to dout.
module react_delay_line
   import player_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 3
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     en,
   input  logic     clr,
   input  ply_cmd_t din,
   output ply_cmd_t dout
);

   generate
      if (DEPTH == 0) begin : g_bypass
         logic unused_ok;
         assign unused_ok = ^{clk, rst_n, en, clr};
         assign dout      = din;
      end else begin : g_shift
         ply_cmd_t stage [DEPTH];

         // clear has priority so a clear on a frame tick leaves the line empty
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               stage <= '{default: '0};
            end else if (clr) begin
               stage <= '{default: '0};
            end else if (en) begin
               stage[0] <= din;
               for (int unsigned i = 1; i < DEPTH; i++) begin
                  stage[i] <= stage[i-1];
               end
            end
         end

         assign dout = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/player_input_arbiter.sv
// Per-player arbiter between human pad and computer player (LOCK/AI/HUMAN).
// Define ARB_AI_JITTER_EN to add LFSR-driven hesitation on AI samples.
module player_input_arbiter
   import player_ctrl_pkg::*;
#(
   parameter int unsigned REACT_FRAMES   = 3,
   parameter int unsigned IDLE_FRAMES    = 180,
   parameter int unsigned JUMP_CD_FRAMES = 20
) (
   input  logic                   clk,
   input  logic                   rst_n,
   player_input_arbiter_if.slave  bus
);

   localparam int unsigned IDLE_W = $clog2(IDLE_FRAMES + 1);
   localparam int unsigned CD_W   = $clog2(JUMP_CD_FRAMES + 1);

   arb_state_t        state, state_nxt;
   logic [IDLE_W-1:0] idle_cnt;
   logic [CD_W-1:0]   cd_cnt;
   ply_cmd_t          hum_cmd, ai_cmd, ai_sample, ai_tail, sel;
   logic              hum_any, idle_expire, dl_shift, dl_clr, cd_clr, fire;

   assign hum_cmd     = {bus.hum_left, bus.hum_right, bus.hum_jump, bus.hum_smash};
   assign ai_cmd      = {bus.ai_left, bus.ai_right, bus.ai_jump, bus.ai_smash};
   assign hum_any     = bus.hum_left | bus.hum_right | bus.hum_jump | bus.hum_smash;
   assign idle_expire = bus.frame_tick && (idle_cnt == IDLE_W'(IDLE_FRAMES - 1));
   assign dl_shift    = bus.frame_tick && (state != LOCK);

`ifdef ARB_AI_JITTER_EN
   logic [7:0] lfsr;
   ply_cmd_t   prev_sample;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr        <= LFSR_SEED;
         prev_sample <= '0;
      end else if (bus.frame_tick) begin
         lfsr <= lfsr_step(lfsr);
         if (dl_shift) prev_sample <= ai_sample;
      end
   end

   assign ai_sample = lfsr[0] ? prev_sample : ai_cmd;
`else
   assign ai_sample = ai_cmd;
`endif

   react_delay_line #(.DEPTH(REACT_FRAMES)) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (dl_shift),
      .clr   (dl_clr),
      .din   (ai_sample),
      .dout  (ai_tail)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= LOCK;
      else        state <= state_nxt;
   end

   // selection follows the next state so a takeover is visible one clk later
   always_comb begin
      state_nxt = state;
      dl_clr    = 1'b0;
      cd_clr    = 1'b0;
      sel       = '0;
      if (!bus.game_active) begin
         state_nxt = LOCK;
      end else begin
         case (state)
            LOCK: begin
               state_nxt = AI;
               dl_clr    = 1'b1;
               cd_clr    = 1'b1;
            end
            AI:      if (hum_any) state_nxt = HUMAN;
            HUMAN: begin
               if (!hum_any && idle_expire) begin
                  state_nxt = AI;
                  dl_clr    = 1'b1;
               end
            end
            default: state_nxt = LOCK;
         endcase
      end
      if (state_nxt == HUMAN)               sel = hum_cmd;
      else if (state_nxt == AI && !dl_clr)  sel = ai_tail;
      fire = sel.jump && (cd_cnt == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt           <= '0;
         cd_cnt             <= '0;
         bus.out_move_left  <= 1'b0;
         bus.out_move_right <= 1'b0;
         bus.out_jump       <= 1'b0;
         bus.out_smash      <= 1'b0;
         bus.src_is_ai      <= 1'b0;
      end else begin
         if (hum_any)                                                idle_cnt <= '0;
         else if (bus.frame_tick && idle_cnt != IDLE_W'(IDLE_FRAMES)) idle_cnt <= idle_cnt + 1'b1;

         if (cd_clr)                              cd_cnt <= '0;
         else if (fire)                           cd_cnt <= CD_W'(JUMP_CD_FRAMES);
         else if (bus.frame_tick && cd_cnt != '0) cd_cnt <= cd_cnt - 1'b1;

         bus.out_move_left  <= sel.left && !sel.right;
         bus.out_move_right <= sel.right && !sel.left;
         bus.out_jump       <= fire;
         bus.out_smash      <= sel.smash;
         bus.src_is_ai      <= (state_nxt == AI);
      end
   end

   assign bus.arb_state = state;

endmodule

// File: tb/tb_player_input_arbiter.sv
// Scoreboard bench for player_input_arbiter: default instance plus a
// REACT_FRAMES=0 instance for the pass-through/conflict case.
module tb_player_input_arbiter;
   import player_ctrl_pkg::*;

   localparam int GAP = 3;
   localparam logic [6:0] M_ALL = 7'b1111111;
   localparam logic [6:0] M_ARB = 7'b1100000;
   localparam logic [6:0] M_L   = 7'b0001000;
   localparam logic [6:0] M_R   = 7'b0000100;
   localparam logic [6:0] M_J   = 7'b0000010;
   localparam logic [6:0] M_OUT = 7'b0001111;

   typedef struct {
      int unsigned cyc;
      int          inst;
      logic [6:0]  mask;
      logic [6:0]  val;
      string       name;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   player_input_arbiter_if bus();
   player_input_arbiter_if bus0();

   player_input_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   player_input_arbiter #(.REACT_FRAMES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          n_cmp = 0, n_fail = 0;
   int          jump_pulses = 0;
   logic        count_en = 1'b0;

   // {arb_state, src_is_ai, left, right, jump, smash}
   function automatic logic [6:0] obs(int inst);
      if (inst == 0)
         return {bus.arb_state, bus.src_is_ai, bus.out_move_left, bus.out_move_right,
                 bus.out_jump, bus.out_smash};
      return {bus0.arb_state, bus0.src_is_ai, bus0.out_move_left, bus0.out_move_right,
              bus0.out_jump, bus0.out_smash};
   endfunction

   task automatic check(string name, logic [6:0] act, logic [6:0] mask, logic [6:0] val);
      n_cmp++;
      if ((act & mask) !== (val & mask)) begin
         n_fail++;
         $display("FAIL %s: got %b, required %b (mask %b)", name, act & mask, val & mask, mask);
      end
   endtask

   task automatic check_int(string name, int act, int val);
      n_cmp++;
      if (act != val) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, val);
      end
   endtask

   task automatic expect_at(int unsigned k, int inst, logic [6:0] mask, logic [6:0] val, string name);
      exp_t e;
      int unsigned i = 0;
      e.cyc = cyc + k; e.inst = inst; e.mask = mask; e.val = val; e.name = name;
      while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
      sb.insert(i, e);
   endtask

   task automatic tick();
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
      repeat (GAP) @(negedge clk);
   endtask

   // monitor: registered outputs are compared 1 time unit after each edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (count_en && bus.out_jump) jump_pulses++;
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
               n_cmp++;
               n_fail++;
               $display("FAIL %s: expectation for cycle %0d not evaluated", e.name, e.cyc);
            end else begin
               check(e.name, obs(e.inst), e.mask, e.val);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, %0d expectations pending", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      bus.frame_tick = 0; bus.game_active = 0;
      bus.hum_left = 0; bus.hum_right = 0; bus.hum_jump = 0; bus.hum_smash = 0;
      bus.ai_left = 0; bus.ai_right = 0; bus.ai_jump = 0; bus.ai_smash = 0;
      bus0.frame_tick = 0; bus0.game_active = 0;
      bus0.hum_left = 0; bus0.hum_right = 0; bus0.hum_jump = 0; bus0.hum_smash = 0;
      bus0.ai_left = 0; bus0.ai_right = 0; bus0.ai_jump = 0; bus0.ai_smash = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      expect_at(1, 0, M_ALL, 7'b0, "reset_state");
      expect_at(1, 1, M_ALL, 7'b0, "reset_state_b0");
      @(negedge clk);

      // LOCK -> AI, AI data appears after 3 frame ticks
      bus.game_active = 1; bus.ai_right = 1;
      expect_at(1, 0, M_ALL, {2'd1, 1'b1, 4'b0000}, "lock_to_ai");
      @(negedge clk);
      for (int i = 1; i <= 3; i++) begin
         expect_at(2, 0, M_OUT, (i == 3) ? M_R : 7'b0, "ai_react_delay");
         tick();
      end

      // human takeover, then idle return after 180 ticks
      bus.hum_left = 1;
      expect_at(1, 0, M_ALL, {2'd2, 1'b0, 4'b1000}, "takeover");
      @(negedge clk);
      bus.hum_left = 0;
      expect_at(1, 0, M_ALL, {2'd2, 1'b0, 4'b0000}, "human_release");
      @(negedge clk);
      for (int i = 1; i <= 180; i++) begin
         if (i == 179) expect_at(1, 0, M_ARB, {2'd2, 5'b0}, "idle_hold");
         if (i == 180) expect_at(1, 0, M_ALL, {2'd1, 1'b1, 4'b0000}, "idle_return");
         tick();
      end
      for (int i = 1; i <= 3; i++) begin
         expect_at(2, 0, M_OUT, (i == 3) ? M_R : 7'b0, "ai_resume");
         tick();
      end

      // held jump: one pulse now, then one per 20 ticks
      bus.hum_jump = 1; count_en = 1;
      expect_at(1, 0, M_ARB | M_J, {2'd2, 5'b00010}, "jump_first");
      expect_at(2, 0, M_J, 7'b0, "jump_first_end");
      repeat (2) @(negedge clk);
      for (int j = 1; j <= 100; j++) begin
         if (j % 20 == 0 && j < 100) begin
            expect_at(1, 0, M_J, 7'b0, "jump_cooldown");
            expect_at(2, 0, M_J, M_J, "jump_pulse");
            expect_at(3, 0, M_J, 7'b0, "jump_pulse_end");
         end
         if (j == 100) expect_at(2, 0, M_J, 7'b0, "jump_no_sixth");
         bus.frame_tick = 1;
         @(negedge clk);
         bus.frame_tick = 0;
         if (j == 100) bus.hum_jump = 0;
         repeat (GAP) @(negedge clk);
      end
      count_en = 0;
      check_int("jump_pulse_count", jump_pulses, 5);

      // game_active drop in HUMAN, then re-entry through LOCK
      bus.hum_smash = 1;
      expect_at(1, 0, M_ALL, {2'd2, 1'b0, 4'b0001}, "human_smash");
      @(negedge clk);
      bus.game_active = 0;
      expect_at(1, 0, M_ALL, 7'b0, "lock_drop");
      @(negedge clk);
      bus.hum_smash = 0; bus.game_active = 1;
      expect_at(1, 0, M_ALL, {2'd1, 1'b1, 4'b0000}, "lock_reenter");
      @(negedge clk);
      for (int i = 1; i <= 3; i++) begin
         expect_at(2, 0, M_OUT, (i == 3) ? M_R : 7'b0, "reenter_ai");
         tick();
      end

      // zero-depth instance: conflict cancels, smash passes
      bus0.game_active = 1; bus0.ai_left = 1; bus0.ai_right = 1; bus0.ai_smash = 1;
      expect_at(1, 1, M_ALL, {2'd1, 1'b1, 4'b0000}, "b0_enter");
      expect_at(2, 1, M_ALL, {2'd1, 1'b1, 4'b0001}, "b0_conflict");
      repeat (2) @(negedge clk);
      bus0.ai_right = 0;
      expect_at(1, 1, M_ALL, {2'd1, 1'b1, 4'b1001}, "b0_left_only");
      repeat (2) @(negedge clk);

      // reset during jump cooldown in HUMAN
      bus.hum_jump = 1;
      expect_at(1, 0, M_ARB | M_J, {2'd2, 5'b00010}, "rst_pre_jump");
      @(negedge clk);
      bus.hum_jump = 0; bus.hum_left = 1;
      tick(); tick();
      expect_at(1, 0, M_ALL, {2'd2, 1'b0, 4'b1000}, "rst_pre_left");
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_outputs", obs(0), M_ALL, 7'b0);
      check("rst_async_outputs_b0", obs(1), M_ALL, 7'b0);
      check_int("rst_cd_cnt", int'(dut.cd_cnt), 0);
`ifdef ARB_AI_JITTER_EN
      check_int("rst_lfsr", int'(dut.lfsr), 8'hA5);
`endif
      bus.hum_left = 0; bus.game_active = 0; bus0.game_active = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_state", obs(0), M_ALL, 7'b0);
      check_int("post_rst_cd_cnt", int'(dut.cd_cnt), 0);
      @(negedge clk);
      expect_at(1, 0, M_ALL, 7'b0, "post_rst_lock");

      for (int w = 0; w < 50 && sb.size() > 0; w++) @(negedge clk);
      while (sb.size() > 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: expectation still pending at end", sb[0].name);
         void'(sb.pop_front());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
